// File: rtl/load_store_unit.sv
// Memory stage: one req/ack data-memory transaction per request,
// load extract/extend, store lane replication, misalign/timeout flags.
module load_store_unit #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   output logic [4:0]  resp_rd,
   output logic [31:0] resp_data,
   output logic        resp_misaligned,
   output logic        resp_fault
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state;
   logic        ready_q;
   logic        st_q;
   logic        uns_q;
   logic [1:0]  size_q;
   logic [1:0]  lane_q;
   logic [4:0]  rd_q;
   logic [31:0] cnt;
   logic        misal;
   logic [3:0]  be_n;
   logic [31:0] wd_n;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;
   logic [31:0] ld_val;
   logic        tmo;

   // ready is held in a flop but masked so it reads 0 while rst is high
   assign req_ready = ready_q & ~rst;

   always_comb begin
      misal = 1'b0;
      be_n  = 4'hf;
      wd_n  = req_wdata;
      unique case (req_size)
         2'b00: begin
            be_n = 4'b0001 << req_addr[1:0];
            wd_n = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            misal = req_addr[0];
            be_n  = 4'b0011 << req_addr[1:0];
            wd_n  = {2{req_wdata[15:0]}};
         end
         default: misal = |req_addr[1:0];
      endcase
   end

   assign ld_b = mem_rdata[{lane_q, 3'b000} +: 8];
   assign ld_h = mem_rdata[{lane_q[1], 4'b0000} +: 16];

   always_comb begin
      unique case (size_q)
         2'b00:   ld_val = {{24{ld_b[7] & ~uns_q}}, ld_b};
         2'b01:   ld_val = {{16{ld_h[15] & ~uns_q}}, ld_h};
         default: ld_val = mem_rdata;
      endcase
   end

   assign tmo = (MEM_TIMEOUT != 32'd0) && (cnt + 32'd1 == MEM_TIMEOUT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         ready_q         <= 1'b1;
         st_q            <= 1'b0;
         uns_q           <= 1'b0;
         size_q          <= 2'b00;
         lane_q          <= 2'b00;
         rd_q            <= 5'd0;
         cnt             <= 32'd0;
         mem_req         <= 1'b0;
         mem_we          <= 1'b0;
         mem_addr        <= 32'd0;
         mem_be          <= 4'd0;
         mem_wdata       <= 32'd0;
         resp_valid      <= 1'b0;
         resp_rd         <= 5'd0;
         resp_data       <= 32'd0;
         resp_misaligned <= 1'b0;
         resp_fault      <= 1'b0;
      end else begin
         resp_valid      <= 1'b0;
         resp_rd         <= 5'd0;
         resp_data       <= 32'd0;
         resp_misaligned <= 1'b0;
         resp_fault      <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  ready_q <= 1'b0;
                  st_q    <= req_store;
                  uns_q   <= req_unsigned;
                  size_q  <= req_size;
                  lane_q  <= req_addr[1:0];
                  rd_q    <= req_rd;
                  if (misal) begin
                     state           <= RESP;
                     resp_valid      <= 1'b1;
                     resp_misaligned <= 1'b1;
                  end else begin
                     state     <= ACCESS;
                     cnt       <= 32'd0;
                     mem_req   <= 1'b1;
                     mem_we    <= req_store;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_be    <= be_n;
                     mem_wdata <= wd_n;
                  end
               end
            end
            ACCESS: begin
               // ack takes priority over a timeout on the same edge
               if (mem_ack || tmo) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  mem_addr   <= 32'd0;
                  mem_be     <= 4'd0;
                  mem_wdata  <= 32'd0;
                  if (mem_ack) begin
                     if (!st_q) begin
                        resp_rd   <= rd_q;
                        resp_data <= ld_val;
                     end
                  end else begin
                     resp_fault <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            RESP: begin
               state   <= IDLE;
               ready_q <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory stage directly downstream of the ALU. It takes the effective address computed by the ALU (`op_out`) together with the decoded load/store attributes and runs one data-memory transaction per request over a req/ack bus. For loads it extracts and extends the addressed byte, half or word; for stores it generates lane-replicated data and byte enables. It returns one response per request to writeback, flagging misaligned accesses and bus timeouts.

## Interface
- `MEM_TIMEOUT`, default 255: cycles to wait for `mem_ack` before a fault is flagged; 0 disables the timeout.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req_valid` in 1: execute presents a memory operation.
- `req_ready` out 1: block can accept a request (IDLE only).
- `req_store` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_unsigned` in 1: zero-extend the load (LBU/LHU); ignored for word and for stores.
- `req_addr` in 32: effective address from the ALU.
- `req_wdata` in 32: store data (rs2).
- `req_rd` in 5: destination register.
- `mem_req` out 1: bus request, held until ack or timeout.
- `mem_we` out 1: write strobe.
- `mem_addr` out 32: word-aligned address, `{req_addr[31:2],2'b00}`.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: bus completion, one cycle.
- `mem_rdata` in 32: read data, valid when `mem_ack`=1.
- `resp_valid` out 1: one-cycle response pulse to writeback (no backpressure).
- `resp_rd` out 5: destination; 0 for stores and for errored loads.
- `resp_data` out 32: load result; 0 otherwise.
- `resp_misaligned` out 1: address misaligned for its size.
- `resp_fault` out 1: bus timeout.

## Operation
- FSM states are IDLE, ACCESS and RESP. All outputs are registered.
- IDLE:
  - `req_ready`=1.
  - A handshake (`req_valid & req_ready`) latches all `req_*` fields.
  - Misaligned (half with `addr[0]`=1, or word with `addr[1:0]`≠0): go to RESP with `resp_misaligned`=1. No bus cycle is issued.
  - Otherwise: go to ACCESS and clear the timeout counter.
- ACCESS:
  - `mem_req`=1 and `mem_we`=`req_store`.
  - `mem_be`: byte `4'b0001<<addr[1:0]`; half `4'b0011<<addr[1:0]`; word `4'b1111`.
  - `mem_wdata`: byte `{4{wdata[7:0]}}`; half `{2{wdata[15:0]}}`; word `wdata`.
  - On `mem_ack`, capture the load result and go to RESP.
  - Without ack, the counter increments each cycle. When it reaches `MEM_TIMEOUT`, go to RESP with `resp_fault`=1.
- Load extraction:
  - byte = `rdata[8*addr[1:0]+:8]`; half = `rdata[16*addr[1]+:16]`.
  - Sign-extend unless `req_unsigned`.
- RESP:
  - `resp_valid`=1 for exactly one cycle, then go to IDLE.
  - `resp_*` fields are valid only while `resp_valid`=1 and are 0 otherwise.
  - Error flags are mutually exclusive.
- `mem_ack` outside ACCESS is ignored: no state change and no response.
- An ack in the same cycle the counter reaches `MEM_TIMEOUT`: the ack wins and there is no fault.

## Timing
- Request accepted at edge N.
- `mem_req`=1 from cycle N+1.
- Ack seen at edge N+1+k (k≥0 wait cycles), so `resp_valid` is high in cycle N+2+k. With k=0, accept-to-response latency is 2 cycles.
- Misaligned: `resp_valid` in cycle N+1; `mem_req` never rises.
- Timeout: `resp_valid` in cycle N+1+`MEM_TIMEOUT`.
- `mem_req` falls in the same cycle `resp_valid` rises.
- `req_ready` returns to 1 in the cycle after `resp_valid`.
- Maximum throughput is one request per 3 cycles.
- Reset:
  - While `rst`=1 and in the cycle after, all outputs are 0 except `req_ready`. `req_ready` is 0 during `rst` and 1 from the first cycle after release.
  - A reset mid-ACCESS abandons the transaction: `mem_req` is 0 in the cycle after the reset edge and no response is emitted.
  - A late `mem_ack` after reset is ignored.

## Test plan
- LW aligned: addr 0x1000; `mem_ack` on the first ACCESS cycle with rdata 0xDEADBEEF → `mem_addr`=0x1000, `mem_be`=0xF, `resp_data`=0xDEADBEEF, `resp_valid` 2 cycles after accept.
- LB/LBU: addr 0x1003, rdata 0x80FF0000 → LB gives 0xFFFFFF80; LBU gives 0x00000080.
- LH/LHU: addr 0x1002, rdata 0x80FF0000 → LH gives 0xFFFF80FF; LHU gives 0x000080FF.
- Byte and half stores:
  - SB at 0x2001, wdata 0x000000AB → `mem_be`=0x2, `mem_wdata`=0xABABABAB, `mem_we`=1, `resp_rd`=0.
  - SH at 0x2002, wdata 0x1234 → `mem_be`=0xC, `mem_wdata`=0x12341234.
- Misaligned LW at 0x1002 → `mem_req` stays 0; `resp_misaligned`=1 in cycle N+1; `resp_rd`=0.
- Timeout, then reset:
  - `MEM_TIMEOUT`=4 and no ack → `resp_fault`=1 in cycle N+5.
  - Then assert `rst` during a second ACCESS → `mem_req` falls next cycle, no response, and a late `mem_ack` is ignored.
